// File: rtl/mem_cmd_pkg.sv
// Shared types, defaults and helpers for the memory command master.
package mem_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_CMD = 3'd1,
        RD_CAP = 3'd2,
        WR_CMD = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h4000_0000;
    localparam int          DEF_DATA_WIDTH = 32;
    localparam int          DEF_ADDR_WIDTH = 32;

    // An address belongs to the region when every base bit is also set in it.
    function automatic logic addr_in_region(input logic [63:0] addr,
                                            input logic [63:0] base);
        return (addr & base) == base;
    endfunction

    // Byte-wise merge of a default-width word: strobed bytes come from new_word.
    function automatic logic [DEF_DATA_WIDTH-1:0] byte_merge(
        input logic [DEF_DATA_WIDTH-1:0]   old_word,
        input logic [DEF_DATA_WIDTH-1:0]   new_word,
        input logic [DEF_DATA_WIDTH/8-1:0] strb
    );
        logic [DEF_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < DEF_DATA_WIDTH / 8; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_cmd_merge.sv
// Combinational byte merge: each strobed byte is taken from new_data,
// every other byte keeps old_data. Width-generic so cache fill logic can reuse it.
module mem_cmd_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;

    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_byte
        assign merged[gi*8 +: 8] = strb[gi] ? new_data[gi*8 +: 8] : old_data[gi*8 +: 8];
    end

endmodule

// File: rtl/mem_cmd_master.sv
// Core-side request/response port to a single-cycle cmd/rd_data memory.
// Partial-strobe writes are turned into read-modify-write sequences because
// the memory has no byte mask. One request is in flight at a time.
module mem_cmd_master
    import mem_cmd_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DEF_BASE_ADDR)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic                      req_wr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   req_strb_i,

    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [DATA_WIDTH-1:0]     resp_rdata_o,
    output logic                      resp_err_o,

    output logic [ADDR_WIDTH-1:0]     cmd_addr_o,
    output logic                      cmd_valid_o,
    output logic                      wr_enable_o,
    output logic [DATA_WIDTH-1:0]     wr_data_o,
    input  logic [DATA_WIDTH-1:0]     rd_data_i
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int BYTE_BITS  = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << BYTE_BITS) - 1);

    state_t state_reg, state_next;

    // Latched request and response payload
    logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;
    logic                  wr_reg,    wr_next;
    logic [DATA_BYTES-1:0] strb_reg,  strb_next;
    logic [DATA_WIDTH-1:0] word_reg,  word_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  err_reg,   err_next;

    // Registered command/response strobes
    logic                  cmd_valid_reg,  cmd_valid_next;
    logic                  wr_enable_reg,  wr_enable_next;
    logic [DATA_WIDTH-1:0] wr_data_reg,    wr_data_next;
    logic                  resp_valid_reg, resp_valid_next;

    logic                  in_region;
    logic                  strb_full;
    logic                  strb_none;
    logic                  accept;
    logic [DATA_WIDTH-1:0] merged_word;

    assign in_region = addr_in_region(64'(req_addr_i), 64'(BASE_ADDR));
    assign strb_full = &req_strb_i;
    assign strb_none = ~|req_strb_i;
    assign accept    = (state_reg == IDLE) && req_valid_i;

    // Old memory word comes straight from rd_data_i; only consumed in RD_CAP.
    mem_cmd_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .old_data (rd_data_i),
        .new_data (word_reg),
        .strb     (strb_reg),
        .merged   (merged_word)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid_i) begin
                    if (!in_region) begin
                        state_next = RESP;
                    end else if (req_wr_i && strb_none) begin
                        state_next = RESP;
                    end else if (req_wr_i && strb_full) begin
                        state_next = WR_CMD;
                    end else begin
                        state_next = RD_CMD;
                    end
                end
            end
            RD_CMD:  state_next = RD_CAP;
            RD_CAP:  state_next = wr_reg ? WR_CMD : RESP;
            WR_CMD:  state_next = RESP;
            RESP:    state_next = resp_ready_i ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Request latch and data capture; rd_data_i is only looked at in RD_CAP
    always_comb begin
        addr_next  = addr_reg;
        wr_next    = wr_reg;
        strb_next  = strb_reg;
        word_next  = word_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        if (accept) begin
            addr_next  = req_addr_i & ~LOW_MASK;
            wr_next    = req_wr_i;
            strb_next  = req_strb_i;
            word_next  = req_wdata_i;
            rdata_next = '0;
            err_next   = !in_region;
        end else if (state_reg == RD_CAP) begin
            if (wr_reg) begin
                word_next = merged_word;
            end else begin
                rdata_next = rd_data_i;
            end
        end
    end

    // Output decode from the upcoming state so the outputs can be registered
    always_comb begin
        cmd_valid_next  = (state_next == RD_CMD) || (state_next == WR_CMD);
        wr_enable_next  = (state_next == WR_CMD);
        wr_data_next    = (state_next == WR_CMD) ? word_next : '0;
        resp_valid_next = (state_next == RESP);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_reg       <= '0;
            wr_reg         <= 1'b0;
            strb_reg       <= '0;
            word_reg       <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            cmd_valid_reg  <= 1'b0;
            wr_enable_reg  <= 1'b0;
            wr_data_reg    <= '0;
            resp_valid_reg <= 1'b0;
        end else begin
            addr_reg       <= addr_next;
            wr_reg         <= wr_next;
            strb_reg       <= strb_next;
            word_reg       <= word_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            cmd_valid_reg  <= cmd_valid_next;
            wr_enable_reg  <= wr_enable_next;
            wr_data_reg    <= wr_data_next;
            resp_valid_reg <= resp_valid_next;
        end
    end

    assign req_ready_o  = (state_reg == IDLE);
    assign resp_valid_o = resp_valid_reg;
    assign resp_rdata_o = rdata_reg;
    assign resp_err_o   = err_reg;
    assign cmd_addr_o   = addr_reg;
    assign cmd_valid_o  = cmd_valid_reg;
    assign wr_enable_o  = wr_enable_reg;
    assign wr_data_o    = wr_data_reg;

endmodule

// File: tb/tb_mem_cmd_master.sv
// Directed bench for mem_cmd_master with a behavioural single-cycle memory,
// a response scoreboard and a command log.
module tb_mem_cmd_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_wr_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_strb_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [31:0] cmd_addr_o;
    logic        cmd_valid_o;
    logic        wr_enable_o;
    logic [31:0] wr_data_o;
    logic [31:0] rd_data_i;

    mem_cmd_master dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_wr_i     (req_wr_i),
        .req_wdata_i  (req_wdata_i),
        .req_strb_i   (req_strb_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .cmd_addr_o   (cmd_addr_o),
        .cmd_valid_o  (cmd_valid_o),
        .wr_enable_o  (wr_enable_o),
        .wr_data_o    (wr_data_o),
        .rd_data_i    (rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    int acc_cyc = 0;

    // Behavioural memory: 16 words, read data valid the cycle after a read command
    logic        mem_init = 1'b1;
    logic [31:0] mem [16];
    logic [31:0] rd_q = '0;
    logic        rd_vld = 1'b0;

    always @(posedge clk_i) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)};
            end
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= 1'b0;
            if (cmd_valid_o) begin
                if (wr_enable_o) begin
                    mem[cmd_addr_o[5:2]] <= wr_data_o;
                end else begin
                    rd_q   <= mem[cmd_addr_o[5:2]];
                    rd_vld <= 1'b1;
                end
            end
        end
    end

    assign rd_data_i = rd_vld ? rd_q : 'x;

    // Command log
    typedef struct packed {
        int          c;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;
    cmd_t cmd_q[$];
    logic prev_cmd = 1'b0;

    always @(negedge clk_i) begin
        if (cmd_valid_o) begin
            cmd_q.push_back('{cyc, wr_enable_o, cmd_addr_o, wr_data_o});
            checks++;
            assert (prev_cmd === 1'b0) passed++;
            else $error("FAIL cmd_back_to_back observed=1 expected=0 at cycle %0d", cyc);
        end
        prev_cmd <= cmd_valid_o;
    end

    // Response scoreboard
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic expect_resp(input logic [31:0] rdata, input logic err, input int lat);
        sb_q.push_back('{rdata, err, lat});
    endtask

    task automatic send(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        int n;
        n = 0;
        @(negedge clk_i);
        cmd_q.delete();
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_wr_i    = wr;
        req_wdata_i = wdata;
        req_strb_i  = strb;
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("req_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        acc_cyc     = cyc;
        req_valid_i = 1'b0;
        $display("req  addr=%h wr=%0d wdata=%h strb=%b accepted at cycle %0d",
                 addr, wr, wdata, strb, acc_cyc);
    endtask

    task automatic get_resp(input int hold);
        int n;
        exp_t x;
        logic [31:0] rd0;
        logic e0;
        n = 0;
        while (resp_valid_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("resp_seen", 64'(resp_valid_o), 64'd1);
        x = sb_q.pop_front();
        check("resp_latency", 64'(cyc - acc_cyc + 1), 64'(x.lat));
        check("resp_rdata", 64'(resp_rdata_o), 64'(x.rdata));
        check("resp_err", 64'(resp_err_o), 64'(x.err));
        $display("resp rdata=%h err=%0d latency=%0d", resp_rdata_o, resp_err_o, cyc - acc_cyc + 1);
        rd0 = resp_rdata_o;
        e0  = resp_err_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check("hold_valid", 64'(resp_valid_o), 64'd1);
            check("hold_rdata", 64'(resp_rdata_o), 64'(rd0));
            check("hold_err", 64'(resp_err_o), 64'(e0));
            check("hold_req_ready", 64'(req_ready_o), 64'd0);
        end
        @(negedge clk_i);
        resp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b0;
        check("resp_dropped", 64'(resp_valid_o), 64'd0);
    endtask

    task automatic check_cmd(input string tag, input int idx, input int rel,
                             input logic wr, input logic [31:0] addr, input logic [31:0] data);
        if (cmd_q.size() > idx) begin
            check({tag, "_cycle"}, 64'(cmd_q[idx].c - acc_cyc), 64'(rel));
            check({tag, "_wr"}, 64'(cmd_q[idx].wr), 64'(wr));
            check({tag, "_addr"}, 64'(cmd_q[idx].addr), 64'(addr));
            if (wr) check({tag, "_data"}, 64'(cmd_q[idx].data), 64'(data));
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_wr_enable", 64'(wr_enable_o), 64'd0);
        check("rst_cmd_addr", 64'(cmd_addr_o), 64'd0);
        check("rst_rdata", 64'(resp_rdata_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        rst_i    = 1'b0;
        mem_init = 1'b0;

        // Plain read
        expect_resp(32'h0706_0504, 1'b0, 3);
        send(32'h4000_0004, 1'b0, 32'h0, 4'h0);
        get_resp(0);
        check("rd_ncmd", 64'(cmd_q.size()), 64'd1);
        check_cmd("rd_cmd", 0, 0, 1'b0, 32'h4000_0004, 32'h0);

        // Full-strobe write, then read back
        expect_resp(32'h0, 1'b0, 2);
        send(32'h4000_0008, 1'b1, 32'hDEAD_BEEF, 4'hF);
        get_resp(0);
        check("fw_ncmd", 64'(cmd_q.size()), 64'd1);
        check_cmd("fw_cmd", 0, 0, 1'b1, 32'h4000_0008, 32'hDEAD_BEEF);
        expect_resp(32'hDEAD_BEEF, 1'b0, 3);
        send(32'h4000_0008, 1'b0, 32'h0, 4'h0);
        get_resp(0);

        // Partial write becomes read-modify-write
        expect_resp(32'h0, 1'b0, 4);
        send(32'h4000_0004, 1'b1, 32'h0000_AB00, 4'b0010);
        get_resp(0);
        check("pw_ncmd", 64'(cmd_q.size()), 64'd2);
        check_cmd("pw_rd", 0, 0, 1'b0, 32'h4000_0004, 32'h0);
        check_cmd("pw_wr", 1, 2, 1'b1, 32'h4000_0004, 32'h0706_AB04);
        expect_resp(32'h0706_AB04, 1'b0, 3);
        send(32'h4000_0004, 1'b0, 32'h0, 4'h0);
        get_resp(0);

        // Out-of-region read
        expect_resp(32'h0, 1'b1, 1);
        send(32'h1000_0000, 1'b0, 32'h0, 4'h0);
        get_resp(0);
        check("err_ncmd", 64'(cmd_q.size()), 64'd0);

        // Unaligned read: low bits dropped
        expect_resp(32'h0706_AB04, 1'b0, 3);
        send(32'h4000_0007, 1'b0, 32'h0, 4'h0);
        get_resp(0);
        check("ua_ncmd", 64'(cmd_q.size()), 64'd1);
        check_cmd("ua_cmd", 0, 0, 1'b0, 32'h4000_0004, 32'h0);

        // Zero-strobe write: response only
        expect_resp(32'h0, 1'b0, 1);
        send(32'h4000_0000, 1'b1, 32'h1234_5678, 4'h0);
        get_resp(0);
        check("zs_ncmd", 64'(cmd_q.size()), 64'd0);

        // Back-pressure: response held 5 cycles while a second request waits
        expect_resp(32'h0302_0100, 1'b0, 3);
        send(32'h4000_0000, 1'b0, 32'h0, 4'h0);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h4000_0008;
        req_wr_i    = 1'b0;
        get_resp(5);
        check("bp_ready_after_hs", 64'(req_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        acc_cyc     = cyc;
        req_valid_i = 1'b0;
        check("bp_second_accepted", 64'(req_ready_o), 64'd0);
        expect_resp(32'hDEAD_BEEF, 1'b0, 3);
        get_resp(0);

        // Reset in RD_CAP of a partial write: no write may be issued
        send(32'h4000_000C, 1'b1, 32'h0000_00FF, 4'b0001);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("mid_rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
        check("mid_rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("mid_rst_wr_enable", 64'(wr_enable_o), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready_o), 64'd1);
        repeat (3) @(posedge clk_i);
        #1;
        check("mid_rst_ncmd", 64'(cmd_q.size()), 64'd1);
        check_cmd("mid_rst_rd", 0, 0, 1'b0, 32'h4000_000C, 32'h0);
        expect_resp(32'h0F0E_0D0C, 1'b0, 3);
        send(32'h4000_000C, 1'b0, 32'h0, 4'h0);
        get_resp(0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_cmd_master.md
Name: mem_cmd_master

Overview:
Initiator for the single-cycle cmd/rd_data memory interface used by the simulation memory model and on-chip RAM shims. It accepts word requests with byte strobes from a core-side valid/ready port and issues cmd_valid/wr_enable commands. Partial-strobe writes become read-modify-write sequences, because the memory interface has no byte mask. Each request returns one response on a valid/ready port. It sits between a load/store unit or test driver and the memory.

Parameters:
BASE_ADDR, 'h4000_0000, region base; an address is valid iff (addr & BASE_ADDR) == BASE_ADDR
DATA_WIDTH, 32, word width; power of 2, >= 8
ADDR_WIDTH, 32, address width
DATA_BYTES (local), DATA_WIDTH/8
BYTE_BITS (local), $clog2(DATA_BYTES)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_addr_i  in  ADDR_WIDTH  byte address
req_wr_i  in  1  1=write, 0=read
req_wdata_i  in  DATA_WIDTH  write data
req_strb_i  in  DATA_BYTES  byte strobes (writes only)
resp_valid_o  out  1  response valid
resp_ready_i  in  1  response accepted
resp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors
resp_err_o  out  1  address outside region
cmd_addr_o  out  ADDR_WIDTH  memory address, low BYTE_BITS forced 0
cmd_valid_o  out  1  command strobe, one cycle per command
wr_enable_o  out  1  1=write command
wr_data_o  out  DATA_WIDTH  write word
rd_data_i  in  DATA_WIDTH  memory read data, valid the cycle after a read command

Behaviour:
- Clock is clk_i. Reset is rst_i, synchronous, active-high.
- All outputs are registered. The exception is req_ready_o, which is the decode state==IDLE.
- Reset values: all outputs 0; state IDLE; latched request 0.
- FSM states: IDLE, RD_CMD, RD_CAP, WR_CMD, RESP.
- IDLE: on req_valid_i, latch address (low bits cleared), wr, wdata and strb. The next state is:
  - RESP with err=1 if the address is invalid (no command issued);
  - RESP with err=0 if it is a write with strb==0 (no command issued);
  - WR_CMD if it is a write with all strobes set;
  - RD_CMD otherwise (read, or partial write).
- RD_CMD: cmd_valid_o=1, wr_enable_o=0 for exactly this cycle; go to RD_CAP.
- RD_CAP: sample rd_data_i.
  - Read: store it as rdata and go to RESP.
  - Partial write: merged[b] = strb[b] ? wdata[b] : rd_data_i[b] per byte; go to WR_CMD.
- WR_CMD: cmd_valid_o=1, wr_enable_o=1, wr_data_o = merged word (or wdata for a full-strobe write); go to RESP.
- RESP: resp_valid_o=1 with rdata/err held stable until resp_ready_i, then go to IDLE.
- rd_data_i is sampled only in RD_CAP; X values outside RD_CAP must not propagate.
- cmd_valid_o is 0 in IDLE, RD_CAP and RESP. It is never high for two consecutive cycles.
- Latency from accept edge to first resp_valid_o cycle:
  - error / zero-strobe write: 1;
  - full write: 2;
  - read: 3;
  - partial write: 4.
- Throughput: one outstanding request. The earliest next accept is the cycle after the response handshake.
- Unaligned address: low BYTE_BITS bits are ignored. No error is raised.
- Reset mid-operation: go to IDLE at the reset edge and drop cmd_valid_o and resp_valid_o.
  - A reset in RD_CMD/RD_CAP of an RMW means no write is issued; memory is unchanged.
  - A reset coincident with WR_CMD means the write may or may not have committed. The verifier must not check that case.

Decomposition:
- Shared package mem_cmd_pkg holds:
  - the state enum;
  - the BASE_ADDR default;
  - the function addr_in_region(addr, base);
  - the function byte_merge(old, new, strb).
- One natural sub-module is mem_cmd_merge: a combinational byte merge, parameterised by DATA_WIDTH. It is reused by future cache fill logic.

Test Plan:
Memory model row i, byte j is preloaded to i*4+j, so the word at row 1 is 0x07060504. BASE_ADDR='h4000_0000.
- Read 0x4000_0004 -> exactly one cmd_valid with wr_enable=0 and cmd_addr 0x4000_0004; resp 3 cycles after accept, rdata 0x07060504, err 0.
- Full write 0xDEADBEEF to 0x4000_0008 with strb 4'hF, then read it -> one write command 1 cycle after accept, no read command; the read returns 0xDEADBEEF.
- Partial write 0x0000AB00 with strb 4'b0010 to 0x4000_0004, then read -> read command then write command with wr_data 0x0706AB04; the read-back returns 0x0706AB04.
- Read 0x1000_0000 -> no cmd_valid; resp next cycle with err=1, rdata 0. Repeat with unaligned 0x4000_0007 -> cmd_addr 0x4000_0004.
- Hold resp_ready_i=0 for 5 cycles after a read -> resp_valid/rdata stable, req_ready_o=0; a second request is accepted only after the handshake.
- Assert rst_i in RD_CAP of a partial write to 0x4000_000C -> no write command; outputs 0 next cycle; read-back returns 0x0F0E0D0C.
